// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream valid/ready/data and downstream valid/ready/data.
// The chain takes the slave view; the producer/consumer side takes the master view.
interface pipe_reg_chain_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic chain of DEPTH valid/data register stages with bubble collapsing,
// strict FIFO order, synchronous flush and synchronous active-high reset.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  pipe_reg_chain_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] move_c;
  logic [DEPTH-1:0] load_c;
  logic             in_ready_c;
  logic             accept_c;

  // A stage moves when it is valid and some stage above it is empty, or the
  // whole run above it is full and the output is draining this cycle.
  always_comb begin
    logic full_above;
    move_c     = '0;
    full_above = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move_c[k]  = v_q[k] & (bus.out_ready | ~full_above);
      full_above = full_above & v_q[k];
    end
  end

  assign in_ready_c = (~v_q[0] | move_c[0]) & ~flush & ~reset;
  assign accept_c   = bus.in_valid & in_ready_c;

  // Next-state for valid bits, data registers and population count.
  always_comb begin
    load_c  = '0;
    v_d     = v_q;
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) begin
        load_c[k] = accept_c;
      end else begin
        load_c[k] = move_c[k-1] & ~flush;
      end
      v_d[k] = load_c[k] | (v_q[k] & ~move_c[k]);
      if (load_c[k]) begin
        d_d[k] = (k == 0) ? bus.in_data : d_q[k-1];
      end
    end

    if (flush) begin
      v_d = '0;
    end

    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign count         = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
module tb_pipe_reg_chain;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [1:0] count;
  int         checks;
  int         errors;

  pipe_reg_chain_if #(.WIDTH(8)) bus ();

  pipe_reg_chain #(
    .WIDTH     (8),
    .DEPTH     (3),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'hA5);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Streaming 01..08 with out_ready high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i < 8);
      bus.in_data  = 8'(i + 1);
      if (i < 8) begin
        #1;
        chk($sformatf("stream_in_ready_%0d", i), 32'(bus.in_ready), 32'd1);
      end
      tick();
      chk($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'(i >= 2));
      if (i >= 2) begin
        chk($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(i - 1));
      end
      chk($sformatf("stream_count_%0d", i), 32'(count),
          (i < 2) ? 32'(i + 1) : (i <= 7) ? 32'd3 : 32'(10 - i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drained_valid", 32'(bus.out_valid), 32'd0);
    chk("stream_drained_count", 32'(count), 32'd0);

    // Backpressure / full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h10 + i);
      #1;
      chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    chk("bp_full_count", 32'(count), 32'd3);
    chk("bp_full_valid", 32'(bus.out_valid), 32'd1);
    bus.in_data = 8'h13;
    #1;
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("bp_hold_data_%0d", i), 32'(bus.out_data), 32'h10);
      chk($sformatf("bp_hold_count_%0d", i), 32'(count), 32'd3);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_full_drain_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out_11", 32'(bus.out_data), 32'h11);
    chk("bp_count_simul", 32'(count), 32'd3);
    tick();
    chk("bp_out_12", 32'(bus.out_data), 32'h12);
    tick();
    chk("bp_out_13", 32'(bus.out_data), 32'h13);
    chk("bp_out_13_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_empty_count", 32'(count), 32'd0);

    // Bubble collapse
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h20;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("bub_head_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_head_data", 32'(bus.out_data), 32'h20);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h21;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("bub_count", 32'(count), 32'd2);
    chk("bub_data", 32'(bus.out_data), 32'h20);
    bus.out_ready = 1'b1;
    tick();
    chk("bub_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_next_data", 32'(bus.out_data), 32'h21);
    tick();
    chk("bub_empty_count", 32'(count), 32'd0);

    // Flush with two entries in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h50;
    tick();
    bus.in_data = 8'h51;
    tick();
    chk("fl_pre_count", 32'(count), 32'd2);
    flush       = 1'b1;
    bus.in_data = 8'h30;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_data_kept", 32'(bus.out_data), 32'h21);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fl_no_30_%0d", i), 32'(bus.out_valid), 32'd0);
    end

    // Mid-stream reset on a full chain
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(8'h60 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mr_full_count", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_data", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h40;
    tick();
    bus.in_valid = 1'b0;
    chk("mr_lat_0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mr_lat_1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mr_lat_2_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_lat_2_data", 32'(bus.out_data), 32'h40);
    tick();
    chk("mr_done_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_done_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
